imm_ext_stage: RTL and testbench

//  Parametrised, pipelined immediate generator for the ID->EX boundary. Decodes an

---
 rtl/imm_ext_stage.sv | 114 +++++++++++
 tb/tb_imm_ext_stage.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/imm_ext_stage.sv
// imm_ext_stage: pipelined immediate/target generator behind a valid/ready skid buffer; ports clk, rst, flush, in_valid/in_ready/in_instr/in_pc/in_mode, out_valid/out_ready/out_imm/out_target; define IMM_EXT_TARGET_EN to compute out_target
module imm_ext_stage #(
  parameter int XLEN   = 32,
  parameter int IMM_W  = 16,
  parameter int JIDX_W = 26
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [2:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [XLEN-1:0] out_target
);
  logic [IMM_W-1:0] imm;
  logic             s;
  logic [XLEN-1:0]  br_imm, jmp_imm, ext_imm;
  logic             accept, emit, load_main;
  logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q, in_ready_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d, skid_imm_q, skid_imm_d;
  logic             unused;
  assign unused = ^in_instr[XLEN-1:JIDX_W];
  always_comb begin
    imm     = in_instr[IMM_W-1:0];
    s       = imm[IMM_W-1];
    br_imm  = {{(XLEN-IMM_W-2){s}}, imm, 2'b00};
    jmp_imm = {in_pc[XLEN-1:JIDX_W+2], in_instr[JIDX_W-1:0], 2'b00};
    ext_imm = in_mode == 3'd0 ? {{(XLEN-IMM_W){1'b0}}, imm} :
              in_mode == 3'd1 ? {{(XLEN-IMM_W){s}}, imm} :
              in_mode == 3'd2 ? {imm, {(XLEN-IMM_W){1'b0}}} :
              in_mode == 3'd3 ? XLEN'(1) :
              in_mode == 3'd4 ? br_imm :
              in_mode == 3'd5 ? jmp_imm :
              in_mode == 3'd6 ? {{(XLEN-5){1'b0}}, in_instr[10:6]} : '0;
  end
`ifdef IMM_EXT_TARGET_EN
  logic [XLEN-1:0] ext_target, out_target_q, out_target_d, skid_target_q, skid_target_d;
  assign ext_target = in_mode == 3'd4 ? in_pc + XLEN'(4) + br_imm :
                      in_mode == 3'd5 ? jmp_imm : '0;
  assign out_target = out_target_q;
`else
  assign out_target = '0;
`endif
  // main reloads whenever it is empty or being drained; skid only catches an accept while main stalls
  always_comb begin
    accept       = in_valid & in_ready_q;
    emit         = out_valid_q & out_ready;
    load_main    = !out_valid_q || emit;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    out_imm_d    = out_imm_q;
    skid_imm_d   = skid_imm_q;
`ifdef IMM_EXT_TARGET_EN
    out_target_d  = out_target_q;
    skid_target_d = skid_target_q;
`endif
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (load_main) begin
      out_valid_d  = skid_valid_q | accept;
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
        out_imm_d = skid_imm_q;
`ifdef IMM_EXT_TARGET_EN
        out_target_d = skid_target_q;
`endif
      end else if (accept) begin
        out_imm_d = ext_imm;
`ifdef IMM_EXT_TARGET_EN
        out_target_d = ext_target;
`endif
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = ext_imm;
`ifdef IMM_EXT_TARGET_EN
      skid_target_d = ext_target;
`endif
    end
    in_ready_d = !skid_valid_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      out_imm_q    <= '0;
      skid_imm_q   <= '0;
`ifdef IMM_EXT_TARGET_EN
      out_target_q  <= '0;
      skid_target_q <= '0;
`endif
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_imm_q    <= out_imm_d;
      skid_imm_q   <= skid_imm_d;
`ifdef IMM_EXT_TARGET_EN
      out_target_q  <= out_target_d;
      skid_target_q <= skid_target_d;
`endif
    end
  end
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign out_imm   = out_imm_q;
endmodule

// File: tb/tb_imm_ext_stage.sv
// tb_imm_ext_stage: directed and randomized self-checking bench for imm_ext_stage
module tb_imm_ext_stage;
  logic        clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_target;
  logic [2:0]  in_mode;
  int          total = 0, bad = 0;
  logic [63:0] q[$];
  logic [63:0] e;
`ifdef IMM_EXT_TARGET_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  imm_ext_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_imm(out_imm), .out_target(out_target)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] m_imm(input logic [31:0] i, input logic [31:0] pc, input logic [2:0] m);
    case (m)
      3'd0: m_imm = {16'h0, i[15:0]};
      3'd1: m_imm = {{16{i[15]}}, i[15:0]};
      3'd2: m_imm = {i[15:0], 16'h0};
      3'd3: m_imm = 32'd1;
      3'd4: m_imm = {{14{i[15]}}, i[15:0], 2'b00};
      3'd5: m_imm = {pc[31:28], i[25:0], 2'b00};
      3'd6: m_imm = {27'h0, i[10:6]};
      default: m_imm = 32'h0;
    endcase
  endfunction
  function automatic logic [31:0] m_tgt(input logic [31:0] i, input logic [31:0] pc, input logic [2:0] m);
    m_tgt = !TEN ? 32'h0 : m == 3'd4 ? pc + 32'd4 + m_imm(i, pc, m) : m == 3'd5 ? m_imm(i, pc, m) : 32'h0;
  endfunction
  task automatic offer(input logic [31:0] i, input logic [31:0] pc, input logic [2:0] m);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = i;
    in_pc    = pc;
    in_mode  = m;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic one(input string tag, input logic [31:0] i, input logic [31:0] pc, input logic [2:0] m,
                     input logic [31:0] ei, input logic [31:0] et);
    offer(i, pc, m);
    chk({tag, "_v"}, 32'(out_valid), 32'd1);
    chk({tag, "_imm"}, out_imm, ei);
    chk({tag, "_tgt"}, out_target, et);
    @(posedge clk);
    #1 chk({tag, "_v0"}, 32'(out_valid), 32'd0);
  endtask
  task automatic pop_push;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("rnd_extra", 32'(out_valid), 32'd0);
      else begin
        e = q.pop_front();
        chk("rnd_imm", out_imm, e[63:32]);
        chk("rnd_tgt", out_target, e[31:0]);
      end
    end
    if (in_valid && in_ready) q.push_back({m_imm(in_instr, in_pc, in_mode), m_tgt(in_instr, in_pc, in_mode)});
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_mode = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v", 32'(out_valid), 32'd0);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_tgt", out_target, 32'h0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 chk("rel_rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    one("sign_neg", 32'h0000_8000, 32'h0, 3'd1, 32'hFFFF_8000, 32'h0);
    one("sign_pos", 32'h0000_7FFF, 32'h0, 3'd1, 32'h0000_7FFF, 32'h0);
    one("zero", 32'hFFFF_8001, 32'h0, 3'd0, 32'h0000_8001, 32'h0);
    one("lui", 32'h0000_8001, 32'h0, 3'd2, 32'h8001_0000, 32'h0);
    one("const", 32'h0000_8001, 32'h0, 3'd3, 32'h0000_0001, 32'h0);
    one("br", 32'h0000_FFFF, 32'h0040_0010, 3'd4, 32'hFFFF_FFFC, TEN ? 32'h0040_0010 : 32'h0);
    one("jmp", 32'h0000_0040, 32'hA000_0000, 3'd5, 32'hA000_0100, TEN ? 32'hA000_0100 : 32'h0);
    one("shamt", 32'hFFFF_FFFF, 32'h0, 3'd6, 32'h0000_001F, 32'h0);
    one("rsvd", 32'hFFFF_FFFF, 32'h0, 3'd7, 32'h0, 32'h0);
    out_ready = 1'b0;
    offer(32'h0000_AAAA, 32'h0, 3'd0);
    offer(32'h0000_BBBB, 32'h0, 3'd0);
    chk("bp_rdy0", 32'(in_ready), 32'd0);
    chk("bp_holdA", out_imm, 32'h0000_AAAA);
    @(posedge clk);
    #1 chk("bp_holdA2", out_imm, 32'h0000_AAAA);
    chk("bp_holdv", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("bp_B", out_imm, 32'h0000_BBBB);
    chk("bp_rdy1", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 chk("bp_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    offer(32'h0000_AAAA, 32'h0, 3'd0);
    offer(32'h0000_BBBB, 32'h0, 3'd0);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h0000_CCCC; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    chk("fl_v", 32'(out_valid), 32'd0);
    chk("fl_rdy", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1 chk("fl_noC", 32'(out_valid), 32'd0);
    offer(32'h0000_DDDD, 32'h0, 3'd0);
    chk("fl_D", out_imm, 32'h0000_DDDD);
    chk("fl_Dv", 32'(out_valid), 32'd1);
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h0000_EEEE; flush = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0; flush = 1'b0;
    chk("fl_dropE", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    offer(32'h0000_1111, 32'h0, 3'd1);
    offer(32'h0000_2222, 32'h0, 3'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1 chk("mrst_v", 32'(out_valid), 32'd0);
    chk("mrst_imm", out_imm, 32'h0);
    chk("mrst_rdy", 32'(in_ready), 32'd0);
    @(negedge clk) rst = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("mrst_quiet", 32'(out_valid), 32'd0);
    chk("mrst_rdy1", 32'(in_ready), 32'd1);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_instr  = $urandom;
      in_pc     = $urandom;
      in_mode   = 3'($urandom_range(0, 7));
      #1 pop_push();
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1 pop_push();
    end
    chk("rnd_left", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
